// File: rtl/mult64_iter_if.sv
// Request/response bundle for the iterative multiplier: operands and start
// flow in, busy/done status and the split product flow back.
interface mult64_iter_if #(parameter int WIDTH = 64);
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] product_hi;
    logic [WIDTH-1:0] product_lo;

    modport master (
        output start, is_signed, a, b,
        input  busy, done, product_hi, product_lo
    );

    modport slave (
        input  start, is_signed, a, b,
        output busy, done, product_hi, product_lo
    );
endinterface

// File: rtl/mult64_iter.sv
// Radix-2 shift-add multiplier: sign-magnitude operands, one partial product
// per cycle, sign applied to the full 2*WIDTH result on the final iteration.
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | waiting for start; product registers hold last result
// BUSY   | iterating, one multiplier bit per cycle, WIDTH cycles
// DONE   | one-cycle done pulse; start here is accepted back-to-back
module mult64_iter #(
    parameter int WIDTH = 64
) (
    input logic         clk,
    input logic         reset,
    mult64_iter_if.slave bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam int         CW     = $clog2(WIDTH + 1);

    logic [1:0]         state;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mplr;
    logic [WIDTH-1:0]   acc_hi;
    logic               neg;
    logic [CW-1:0]      cnt;
    logic               busy_r;
    logic               done_r;
    logic [WIDTH-1:0]   prod_hi_r;
    logic [WIDTH-1:0]   prod_lo_r;

    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] raw;
    logic [2*WIDTH-1:0] res;
    logic               accept;
    logic               last;

    // The most-negative operand negates to itself, which is its correct
    // unsigned magnitude, so no special case is needed.
    always_comb begin
        mag_a  = (bus.is_signed && bus.a[WIDTH-1]) ? (~bus.a + 1'b1) : bus.a;
        mag_b  = (bus.is_signed && bus.b[WIDTH-1]) ? (~bus.b + 1'b1) : bus.b;
        sum    = {1'b0, acc_hi} + (mplr[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
        raw    = {sum, mplr[WIDTH-1:1]};
        res    = neg ? (~raw + 1'b1) : raw;
        accept = bus.start && ((state == S_IDLE) || (state == S_DONE));
        last   = (state == S_BUSY) && (cnt == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            mcand     <= '0;
            mplr      <= '0;
            acc_hi    <= '0;
            neg       <= 1'b0;
            cnt       <= '0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            prod_hi_r <= '0;
            prod_lo_r <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    done_r <= 1'b0;
                    if (accept) begin
                        mcand  <= mag_a;
                        mplr   <= mag_b;
                        neg    <= bus.is_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                        acc_hi <= '0;
                        cnt    <= '0;
                        busy_r <= 1'b1;
                        state  <= S_BUSY;
                    end else begin
                        state  <= S_IDLE;
                    end
                end
                S_BUSY: begin
                    acc_hi <= sum[WIDTH:1];
                    mplr   <= {sum[0], mplr[WIDTH-1:1]};
                    cnt    <= cnt + CW'(1);
                    if (last) begin
                        prod_hi_r <= res[2*WIDTH-1:WIDTH];
                        prod_lo_r <= res[WIDTH-1:0];
                        busy_r    <= 1'b0;
                        done_r    <= 1'b1;
                        state     <= S_DONE;
                    end
                end
                default: begin
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy       = busy_r;
    assign bus.done       = done_r;
    assign bus.product_hi = prod_hi_r;
    assign bus.product_lo = prod_lo_r;
endmodule
